icache: RTL

Instruction cache plus fetch-PC generator sitting directly upstream of the IF queue.
- Holds the sequential fetch PC.
- Looks up a direct-mapped, 4-word-line cache, refilling missed lines word by word from the memory controller.
- Delivers at most one instruction/PC pair per cycle to IF while IF reports space.
- A ROB redirect (branch mispredict or exception) flushes the fetch stream and restarts at a new PC.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_line_store.sv | 56 +++++
 rtl/icache.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: line geometry, reset PC and FSM encoding.
package icache_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  localparam int unsigned WORDS_PER_LINE   = 4;
  localparam int unsigned OFFSET_BITS      = 2;
  localparam int unsigned BYTE_BITS        = 2;
  localparam int unsigned DEF_INDEX_BITS   = 4;

  function automatic int unsigned tag_bits(input int unsigned index_bits);
    return 32 - OFFSET_BITS - BYTE_BITS - index_bits;
  endfunction

  localparam int unsigned TAG_BITS = tag_bits(DEF_INDEX_BITS);

  localparam logic [1:0] StLookup = 2'd0;
  localparam logic [1:0] StRefill = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped tag/valid/data arrays: combinational read by index, synchronous word write.
module icache_line_store import icache_pkg::*; #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_W      = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [INDEX_BITS-1:0]  rd_index_i,
  input  logic [OFFSET_BITS-1:0] rd_offset_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [31:0]            rd_data_o,
  input  logic [INDEX_BITS-1:0]  wr_index_i,
  input  logic                   wr_word_en_i,
  input  logic [OFFSET_BITS-1:0] wr_offset_i,
  input  logic [31:0]            wr_data_i,
  input  logic                   wr_fill_done_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic                   clr_valid_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (en_i) begin
      if (clr_valid_i) begin
        valid_q[wr_index_i] <= 1'b0;
      end else if (wr_fill_done_i) begin
        valid_q[wr_index_i] <= 1'b1;
      end
    end
  end

  // Payload arrays need no reset: nothing is read from a line until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wr_word_en_i) begin
        data_q[wr_index_i][wr_offset_i] <= wr_data_i;
      end
      if (wr_fill_done_i) begin
        tag_q[wr_index_i] <= wr_tag_i;
      end
    end
  end

endmodule

// File: rtl/icache.sv
// Fetch-PC generator and direct-mapped instruction cache feeding the IF queue,
// refilling missed lines one word at a time from the memory controller.
module icache import icache_pkg::*; #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned INDEX_BITS = 4,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        IF_not_full,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        have_output,
  output logic [31:0] instr_output,
  output logic [31:0] instr_pc_output
);

  localparam int unsigned TagW = tag_bits(INDEX_BITS);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        have_q, have_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        req_v_q, req_v_d;
  logic [31:0] req_a_q, req_a_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  pc_index, req_index, wr_index;
  logic [TagW-1:0]        pc_tag, req_tag, rd_tag;
  logic                   rd_valid;
  logic [31:0]            rd_data;
  logic                   hit;
  logic                   word_we, fill_done, clr_valid;

  assign pc_offset = pc_q[3:2];
  assign pc_index  = pc_q[3+INDEX_BITS:4];
  assign pc_tag    = pc_q[31:4+INDEX_BITS];
  // The outstanding request address always identifies the line being refilled.
  assign req_index = req_a_q[3+INDEX_BITS:4];
  assign req_tag   = req_a_q[31:4+INDEX_BITS];
  assign wr_index  = (state_q == StLookup) ? pc_index : req_index;

  assign hit = (state_q == StLookup) && rd_valid && (rd_tag == pc_tag);

  icache_line_store #(
    .LINES      (LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TagW)
  ) u_store (
    .clk_i          (clk_in),
    .rst_i          (rst_in),
    .en_i           (rdy_in),
    .rd_index_i     (pc_index),
    .rd_offset_i    (pc_offset),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_data_o      (rd_data),
    .wr_index_i     (wr_index),
    .wr_word_en_i   (word_we),
    .wr_offset_i    (cnt_q),
    .wr_data_i      (mem_resp_data),
    .wr_fill_done_i (fill_done),
    .wr_tag_i       (req_tag),
    .clr_valid_i    (clr_valid)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    have_d    = 1'b0;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    req_v_d   = req_v_q;
    req_a_d   = req_a_q;
    cnt_d     = cnt_q;
    word_we   = 1'b0;
    fill_done = 1'b0;
    clr_valid = 1'b0;

    unique case (state_q)
      StLookup: begin
        if (rob_clear) begin
          pc_d = rob_new_pc;
        end else if (hit) begin
          if (IF_not_full) begin
            have_d  = 1'b1;
            instr_d = rd_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
          end
        end else begin
          req_v_d   = 1'b1;
          req_a_d   = {pc_q[31:4], 4'b0000};
          cnt_d     = 2'd0;
          clr_valid = 1'b1;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        if (rob_clear) begin
          pc_d = rob_new_pc;
          if (mem_resp_valid) begin
            req_v_d = 1'b0;
            state_d = StLookup;
          end else begin
            state_d = StDrain;
          end
        end else if (mem_resp_valid) begin
          word_we = 1'b1;
          if (cnt_q == 2'd3) begin
            req_v_d   = 1'b0;
            fill_done = 1'b1;
            state_d   = StLookup;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            req_a_d = {req_a_q[31:4], cnt_q + 2'd1, 2'b00};
          end
        end
      end
      StDrain: begin
        if (rob_clear) begin
          pc_d = rob_new_pc;
        end
        // The outstanding word belongs to an abandoned line; consume and drop it.
        if (mem_resp_valid) begin
          req_v_d = 1'b0;
          state_d = StLookup;
        end
      end
      default: begin
        state_d = StLookup;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StLookup;
      pc_q    <= RESET_PC;
      have_q  <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      req_v_q <= 1'b0;
      req_a_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      have_q  <= have_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      req_v_q <= req_v_d;
      req_a_q <= req_a_d;
      cnt_q   <= cnt_d;
    end
  end

  assign have_output     = have_q;
  assign instr_output    = instr_q;
  assign instr_pc_output = ipc_q;
  assign mem_req_valid   = req_v_q;
  assign mem_req_addr    = req_a_q;

endmodule
